// File: rtl/seg_pkg.sv
// Shared types for the 7-segment scan controller: digit record, scan states, dark pattern.
// Pure declarations; no logic, no latency.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef struct packed {
    logic       blank;
    logic [3:0] data;
  } digit_t;

  // Prefixed so the state names cannot collide with the GUARD parameter of the top.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GUARD,
    ST_SHOW
  } scan_state_t;

endpackage

// File: rtl/seg.sv
// Hex to active-low 7-segment decoder (bit0 = a .. bit6 = g).
// Combinational, zero latency; no backpressure.
module seg
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] segs
);

  always_comb begin
    segs = SEG_OFF;
    case (hex)
      4'h0: segs = 7'h40;
      4'h1: segs = 7'h79;
      4'h2: segs = 7'h24;
      4'h3: segs = 7'h30;
      4'h4: segs = 7'h19;
      4'h5: segs = 7'h12;
      4'h6: segs = 7'h02;
      4'h7: segs = 7'h78;
      4'h8: segs = 7'h00;
      4'h9: segs = 7'h10;
      4'hA: segs = 7'h08;
      4'hB: segs = 7'h03;
      4'hC: segs = 7'h46;
      4'hD: segs = 7'h21;
      4'hE: segs = 7'h06;
      4'hF: segs = 7'h0E;
      default: segs = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed scanner for NDIG common-anode digits with shadow/active banks committed on frame wrap.
// Outputs registered (1 cycle after state/idx); wr_ready low while a commit is pending, writes then dropped.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NDIG  = 8,
  parameter int DIV   = 50000,
  parameter int GUARD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            wr_en,
  input  logic [2:0]      wr_idx,
  input  logic [3:0]      wr_data,
  input  logic            wr_blank,
  input  logic            wr_commit,
  output logic            wr_ready,
  output logic [6:0]      seg_o,
  output logic [NDIG-1:0] an_o,
  output logic            frame_o
);

  localparam int PW = $clog2(DIV);
  localparam int IW = $clog2(NDIG);
  localparam logic [PW-1:0] PC_LAST    = PW'(DIV - 1);
  localparam logic [PW-1:0] GUARD_LAST = PW'(GUARD - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

  scan_state_t   state;
  logic [PW-1:0] pc;
  logic [IW-1:0] idx;
  logic          pending;
  digit_t        shadow [NDIG];
  digit_t        active [NDIG];
  logic [6:0]    dec;

  logic tick, wrap, wr_take, commit_now;

  assign tick       = (state == ST_SHOW) && (pc == PC_LAST);
  assign wrap       = tick && (idx == IDX_LAST);
  assign wr_take    = wr_en && !pending && ({29'd0, wr_idx} < 32'(NDIG));
  // Copy lands on the wrap edge while scanning, or on the first edge spent in IDLE.
  assign commit_now = pending && ((state == ST_IDLE) || (en && wrap));
  assign wr_ready   = !pending;

  seg u_seg (
    .hex  (active[idx].data),
    .segs (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      for (int i = 0; i < NDIG; i++) begin
        shadow[i] <= {1'b1, 4'h0};
        active[i] <= {1'b1, 4'h0};
      end
    end else begin
      if (wr_take) begin
        shadow[wr_idx[IW-1:0]] <= {wr_blank, wr_data};
      end
      if (commit_now) begin
        active  <= shadow;
        pending <= 1'b0;
      end else if (wr_commit && !pending) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pc      <= '0;
      idx     <= '0;
      seg_o   <= SEG_OFF;
      an_o    <= '1;
      frame_o <= 1'b0;
    end else begin
      frame_o <= 1'b0;
      an_o    <= '1;
      seg_o   <= SEG_OFF;
      // Gating with en darkens the pins on the same edge that leaves SHOW.
      if (en && (state == ST_SHOW)) begin
        an_o  <= ~({{(NDIG-1){1'b0}}, 1'b1} << idx);
        seg_o <= active[idx].blank ? SEG_OFF : dec;
      end
      if (!en) begin
        state <= ST_IDLE;
        pc    <= '0;
        idx   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_GUARD;
            pc    <= '0;
            idx   <= '0;
          end
          ST_GUARD: begin
            pc <= pc + PW'(1);
            if (pc == GUARD_LAST) state <= ST_SHOW;
          end
          ST_SHOW: begin
            if (tick) begin
              state   <= ST_GUARD;
              pc      <= '0;
              idx     <= wrap ? '0 : idx + IW'(1);
              frame_o <= wrap;
            end else begin
              pc <= pc + PW'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NDIG=4, DIV=4, GUARD=1 (one dark cycle, three lit cycles per digit).
module tb_seg_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int DIV   = 4;
  localparam int GUARD = 1;

  // Anode pattern across one frame, starting at the dark slot of digit 0.
  localparam logic [3:0] AN_SEQ [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                                         4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_idx = 3'd0;
  logic [3:0] wr_data = 4'h0;
  logic       wr_blank = 1'b0;
  logic       wr_commit = 1'b0;
  logic       wr_ready;
  logic [6:0] seg_o;
  logic [3:0] an_o;
  logic       frame_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .GUARD(GUARD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .wr_blank  (wr_blank),
    .wr_commit (wr_commit),
    .wr_ready  (wr_ready),
    .seg_o     (seg_o),
    .an_o      (an_o),
    .frame_o   (frame_o)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #10;
    checks++; if (seg_o !== 7'h7F) begin failures++; $display("FAIL reset_seg got=%h exp=7f", seg_o); end
    checks++; if (an_o !== 4'hF) begin failures++; $display("FAIL reset_an got=%h exp=f", an_o); end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_rdy got=%b exp=1", wr_ready); end
    checks++; if (frame_o !== 1'b0) begin failures++; $display("FAIL reset_frame got=%b exp=0", frame_o); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (an_o !== 4'hF) begin failures++; $display("FAIL idle_an got=%h exp=f", an_o); end
  endtask

  task automatic test_idle_scan();
    en = 1'b1;
    @(negedge clk);
    checks++; if (an_o !== 4'hF) begin failures++; $display("FAIL scan_start_an got=%h exp=f", an_o); end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++; if (an_o !== AN_SEQ[k]) begin failures++; $display("FAIL scan_an k=%0d got=%h exp=%h", k, an_o, AN_SEQ[k]); end
      checks++; if (seg_o !== 7'h7F) begin failures++; $display("FAIL scan_seg k=%0d got=%h exp=7f", k, seg_o); end
      checks++; if (frame_o !== (k == 15)) begin failures++; $display("FAIL scan_frame k=%0d got=%b", k, frame_o); end
    end
  endtask

  task automatic test_commit();
    logic [3:0] vals [4];
    logic [6:0] exp_seg [4];
    int n;
    vals = '{4'h1, 4'h2, 4'h3, 4'hA};
    exp_seg = '{7'h79, 7'h24, 7'h30, 7'h08};
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_idx = 3'(i); wr_data = vals[i]; wr_blank = 1'b0;
      @(negedge clk);
    end
    wr_en = 1'b0; wr_commit = 1'b1;
    @(negedge clk);
    wr_commit = 1'b0;
    n = 0;
    while (frame_o !== 1'b1 && n < 40) begin
      checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL commit_rdy_low n=%0d got=%b exp=0", n, wr_ready); end
      checks++; if (seg_o !== 7'h7F) begin failures++; $display("FAIL commit_old_seg n=%0d got=%h exp=7f", n, seg_o); end
      @(negedge clk);
      n++;
    end
    checks++; if (frame_o !== 1'b1) begin failures++; $display("FAIL commit_frame_timeout got=%b exp=1", frame_o); end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL commit_rdy_back got=%b exp=1", wr_ready); end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++; if (an_o !== AN_SEQ[k]) begin failures++; $display("FAIL commit_an k=%0d got=%h exp=%h", k, an_o, AN_SEQ[k]); end
      checks++; if (seg_o !== ((k % 4 == 0) ? 7'h7F : exp_seg[k/4])) begin failures++; $display("FAIL commit_seg k=%0d got=%h", k, seg_o); end
    end
  endtask

  task automatic test_midframe_commit();
    logic [6:0] old_seg [4];
    logic [6:0] new_seg [4];
    old_seg = '{7'h79, 7'h24, 7'h30, 7'h08};
    new_seg = '{7'h79, 7'h24, 7'h12, 7'h46};
    for (int k = 0; k < 16; k++) begin
      wr_en = (k < 2); wr_idx = (k == 0) ? 3'd2 : 3'd3; wr_data = (k == 0) ? 4'h5 : 4'hC;
      wr_commit = (k == 5);
      @(negedge clk);
      checks++; if (an_o !== AN_SEQ[k]) begin failures++; $display("FAIL mid_an k=%0d got=%h exp=%h", k, an_o, AN_SEQ[k]); end
      checks++; if (seg_o !== ((k % 4 == 0) ? 7'h7F : old_seg[k/4])) begin failures++; $display("FAIL mid_old_seg k=%0d got=%h", k, seg_o); end
      checks++; if (wr_ready !== !(k >= 5 && k < 15)) begin failures++; $display("FAIL mid_rdy k=%0d got=%b", k, wr_ready); end
      checks++; if (frame_o !== (k == 15)) begin failures++; $display("FAIL mid_frame k=%0d got=%b", k, frame_o); end
    end
    wr_en = 1'b0; wr_commit = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++; if (seg_o !== ((k % 4 == 0) ? 7'h7F : new_seg[k/4])) begin failures++; $display("FAIL mid_new_seg k=%0d got=%h", k, seg_o); end
    end
  endtask

  task automatic test_dropped_writes();
    logic [6:0] exp_seg [4];
    exp_seg = '{7'h79, 7'h24, 7'h12, 7'h46};
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 16; k++) begin
        wr_en = (f == 0) && (k == 0 || k == 3);
        wr_idx = (k == 0) ? 3'd5 : 3'd0;
        wr_data = (k == 0) ? 4'h8 : 4'hF;
        wr_commit = (f == 0) && (k == 2);
        @(negedge clk);
        checks++; if (seg_o !== ((k % 4 == 0) ? 7'h7F : exp_seg[k/4])) begin failures++; $display("FAIL drop_seg f=%0d k=%0d got=%h", f, k, seg_o); end
        if (f == 0) begin
          checks++; if (wr_ready !== !(k >= 2 && k < 15)) begin failures++; $display("FAIL drop_rdy k=%0d got=%b", k, wr_ready); end
        end
      end
    end
    wr_en = 1'b0; wr_commit = 1'b0;
  endtask

  task automatic test_en_drop();
    logic [6:0] exp_seg [4];
    exp_seg = '{7'h00, 7'h24, 7'h12, 7'h46};
    for (int k = 0; k < 7; k++) begin
      wr_en = (k == 0); wr_idx = 3'd0; wr_data = 4'h8;
      wr_commit = (k == 1);
      en = (k != 6);
      @(negedge clk);
    end
    wr_en = 1'b0; wr_commit = 1'b0;
    checks++; if (an_o !== 4'hF) begin failures++; $display("FAIL endrop_an got=%h exp=f", an_o); end
    checks++; if (seg_o !== 7'h7F) begin failures++; $display("FAIL endrop_seg got=%h exp=7f", seg_o); end
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL endrop_rdy1 got=%b exp=0", wr_ready); end
    @(negedge clk);
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL endrop_rdy2 got=%b exp=1", wr_ready); end
    en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      en = (k != 15);
      @(negedge clk);
      if (k < 15) begin
        checks++; if (an_o !== AN_SEQ[k]) begin failures++; $display("FAIL reen_an k=%0d got=%h exp=%h", k, an_o, AN_SEQ[k]); end
        checks++; if (seg_o !== ((k % 4 == 0) ? 7'h7F : exp_seg[k/4])) begin failures++; $display("FAIL reen_seg k=%0d got=%h", k, seg_o); end
      end else begin
        checks++; if (an_o !== 4'hF) begin failures++; $display("FAIL tick_en_an got=%h exp=f", an_o); end
        checks++; if (frame_o !== 1'b0) begin failures++; $display("FAIL tick_en_frame got=%b exp=0", frame_o); end
      end
    end
  endtask

  task automatic test_async_reset();
    en = 1'b1; wr_en = 1'b1; wr_idx = 3'd0; wr_data = 4'h3; wr_blank = 1'b0;
    @(negedge clk);
    wr_en = 1'b0; wr_commit = 1'b1;
    @(negedge clk);
    wr_commit = 1'b0;
    @(negedge clk);
    checks++; if (an_o !== 4'hE) begin failures++; $display("FAIL prerst_an got=%h exp=e", an_o); end
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL prerst_rdy got=%b exp=0", wr_ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (an_o !== 4'hF) begin failures++; $display("FAIL arst_an got=%h exp=f", an_o); end
    checks++; if (seg_o !== 7'h7F) begin failures++; $display("FAIL arst_seg got=%h exp=7f", seg_o); end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL arst_rdy got=%b exp=1", wr_ready); end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wr_commit = 1'b1;
    @(negedge clk);
    wr_commit = 1'b0;
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL postrst_rdy_low got=%b exp=0", wr_ready); end
    @(negedge clk);
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL postrst_rdy_high got=%b exp=1", wr_ready); end
    en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++; if (an_o !== AN_SEQ[k]) begin failures++; $display("FAIL postrst_an k=%0d got=%h exp=%h", k, an_o, AN_SEQ[k]); end
      checks++; if (seg_o !== 7'h7F) begin failures++; $display("FAIL postrst_seg k=%0d got=%h exp=7f", k, seg_o); end
      checks++; if (frame_o !== (k == 15)) begin failures++; $display("FAIL postrst_frame k=%0d got=%b", k, frame_o); end
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_commit();
    test_midframe_commit();
    test_dropped_writes();
    test_en_drop();
    test_async_reset();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
